// File: rtl/rr_bus_mux_pkg.sv
// Shared constants and helpers for the round-robin bus multiplexer
// and the other parametrised bus blocks.
package rr_bus_mux_pkg;

  // Output register occupancy (EMPTY / FULL)
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // Channel-index width; never below one bit
  function automatic int ch_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Pointer reset value: last channel, so channel 0 is searched first
  function automatic int ptr_rst(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_bus_mux_arbiter.sv
// rr_arbiter: combinational round-robin grant from req/ptr.
// Ports: req_i, ptr_i -> gnt_o (one-hot), idx_o (binary), any_o.
module rr_arbiter
  import rr_bus_mux_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CH_W    = ch_w(NUM_CH),
  parameter bit PRIO_EN = 1'b0
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  logic          found;
  int            c;
  logic [CH_W-1:0] sel;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    sel   = '0;
    // Strict priority: channel 0 pre-empts the rotation
    if (PRIO_EN && req_i[0]) begin
      gnt_o[0] = 1'b1;
      found    = 1'b1;
    end
    // Search ptr+1 upward, wrapping; ptr itself comes last
    for (int k = 1; k <= NUM_CH; k++) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      sel = CH_W'(c);
      if (!found && req_i[sel] && !(PRIO_EN && c == 0)) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/rr_bus_mux.sv
// rr_bus_mux: registered N-channel round-robin mux with valid/ready.
// Ports: in_valid/in_data/in_ready (NUM_CH producers), out_valid/
// out_data/out_ch/out_ready (one consumer). Option: RR_BUS_MUX_PRIO_EN
// gives channel 0 strict priority.
module rr_bus_mux
  import rr_bus_mux_pkg::*;
#(
  parameter  int DATA_W = 2,
  parameter  int NUM_CH = 8,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

`ifdef RR_BUS_MUX_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [CH_W-1:0] PTR_RST = CH_W'(ptr_rst(NUM_CH));

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gidx;
  logic              any;
  logic              load_ok;
  logic              accept;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W),
    .PRIO_EN (PRIO_EN)
  ) u_arb (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  assign load_ok = (valid_q == ST_EMPTY) || out_ready;
  assign accept  = load_ok && any;

  // rst_n gating keeps in_ready low while reset is held
  assign in_ready = (rst_n && load_ok) ? gnt : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d = ST_FULL;
      // Only the granted lane is selected, so X elsewhere stays out
      data_d  = in_data[gidx*DATA_W +: DATA_W];
      ch_d    = gidx;
      if (!(PRIO_EN && gidx == '0)) ptr_d = gidx;
    end else if (out_ready) begin
      valid_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_bus_mux.sv
// Self-checking bench for rr_bus_mux.
// Scoreboard of expected words plus fixed grant-order checks.
module tb_rr_bus_mux;

  localparam int N  = 8;
  localparam int DW = 2;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ch;
  logic            out_ready;

  rr_bus_mux #(.DATA_W(DW), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   mptr;
  bit   mvalid;

  function automatic int mdl_grant(input logic [N-1:0] req, input int p);
`ifdef RR_BUS_MUX_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
`ifdef RR_BUS_MUX_PRIO_EN
      if (c == 0) continue;
`endif
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Advance one cycle; model predicts the grant and queues the word
  task automatic tick(output logic [N-1:0] er, output logic [N-1:0] gr,
                      output bit acc);
    int g;
    bit lok;
    #1;
    gr  = in_ready;
    g   = mdl_grant(in_valid, mptr);
    lok = !mvalid || out_ready;
    er  = '0;
    acc = 1'b0;
    if (lok && g >= 0) begin
      er[g] = 1'b1;
      acc   = 1'b1;
      exp_q.push_back({CW'(g), in_data[g*DW +: DW]});
      mvalid = 1'b1;
`ifdef RR_BUS_MUX_PRIO_EN
      if (g != 0) mptr = g;
`else
      mptr = g;
`endif
    end else if (out_ready) begin
      mvalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mptr   = N - 1;
    mvalid = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_data_mod4();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(i % 4);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] er, gr;
    bit acc;
    exp_t e;
    do_reset();
    set_data_mod4();
    out_ready = 1'b1;
    in_valid  = '1;
    for (int k = 0; k < 9; k++) begin
      tick(er, gr, acc);
      n_chk++;
      if (gr !== er) $display("FAIL rr_ready[%0d] got %b want %b", k, gr, er);
      else n_pass++;
      n_chk++;
      if (!acc || out_valid !== 1'b1 || out_ch !== CW'(k % N))
        $display("FAIL rr_seq[%0d] got v=%b ch=%0d want v=1 ch=%0d",
                 k, out_valid, out_ch, k % N);
      else n_pass++;
      if (acc) begin
        e = exp_q.pop_front();
        n_chk++;
        if (out_data !== e.data)
          $display("FAIL rr_data[%0d] got %0d want %0d", k, out_data, e.data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] er, gr;
    bit acc;
    exp_t e;
    logic [CW-1:0] sch;
    logic [DW-1:0] sdat;
    sch  = out_ch;
    sdat = out_data;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(er, gr, acc);
      n_chk++;
      if (gr !== '0 || acc || out_valid !== 1'b1 ||
          out_ch !== sch || out_data !== sdat)
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b ch=%0d d=%0d want rdy=0 v=1 ch=%0d d=%0d",
                 k, gr, out_valid, out_ch, out_data, sch, sdat);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick(er, gr, acc);
    n_chk++;
    if (!acc || gr !== er) $display("FAIL bp_release got rdy=%b want %b", gr, er);
    else n_pass++;
    if (acc) begin
      e = exp_q.pop_front();
      n_chk++;
      if (out_valid !== 1'b1 || out_ch !== e.ch || out_data !== e.data ||
          e.ch !== CW'((int'(sch) + 1) % N))
        $display("FAIL bp_word got ch=%0d d=%0d want ch=%0d d=%0d",
                 out_ch, out_data, e.ch, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_sparse();
    logic [N-1:0] er, gr;
    bit acc;
    exp_t e;
    int seq[4];
    seq = '{3, 6, 3, 6};
    do_reset();
    out_ready = 1'b1;
    in_data   = 'x;
    in_data[6*DW +: DW] = 2'b10;
    in_data[3*DW +: DW] = 2'b01;
    in_valid  = 8'b0100_0000;
    tick(er, gr, acc);
    if (acc) void'(exp_q.pop_front());
    in_valid = 8'b0100_1000;
    for (int k = 0; k < 4; k++) begin
      tick(er, gr, acc);
      n_chk++;
      if (!acc || out_ch !== CW'(seq[k]) || gr !== er)
        $display("FAIL sparse_seq[%0d] got ch=%0d rdy=%b want ch=%0d rdy=%b",
                 k, out_ch, gr, seq[k], er);
      else n_pass++;
      if (acc) begin
        e = exp_q.pop_front();
        n_chk++;
        if (out_data !== e.data)
          $display("FAIL sparse_data[%0d] got %b want %b", k, out_data, e.data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_drain();
    logic [N-1:0] er, gr;
    bit acc;
    exp_t e;
    do_reset();
    set_data_mod4();
    in_data[5*DW +: DW] = 2'b11;
    out_ready = 1'b1;
    in_valid  = 8'b0010_0000;
    tick(er, gr, acc);
    in_valid = '0;
    if (acc) begin
      e = exp_q.pop_front();
      n_chk++;
      if (out_valid !== 1'b1 || out_ch !== 3'd5 || out_data !== e.data)
        $display("FAIL drain_load got v=%b ch=%0d d=%0d want v=1 ch=5 d=%0d",
                 out_valid, out_ch, out_data, e.data);
      else n_pass++;
    end else begin
      n_chk++;
      $display("FAIL drain_accept got none want ch5");
    end
    for (int k = 0; k < 2; k++) begin
      tick(er, gr, acc);
      n_chk++;
      if (acc || out_valid !== 1'b0 || out_ch !== 3'd5 || out_data !== 2'b11)
        $display("FAIL drain_empty[%0d] got v=%b ch=%0d d=%0d want v=0 ch=5 d=3",
                 k, out_valid, out_ch, out_data);
      else n_pass++;
    end
  endtask

  task automatic test_prio();
    logic [N-1:0] er, gr;
    bit acc;
    exp_t e;
    int seq[7];
`ifdef RR_BUS_MUX_PRIO_EN
    seq = '{0, 0, 0, 0, 2, 4, 2};
`else
    seq = '{0, 2, 4, 0, 2, 4, 2};
`endif
    do_reset();
    set_data_mod4();
    out_ready = 1'b1;
    in_valid  = 8'b0001_0101;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) in_valid = 8'b0001_0100;
      tick(er, gr, acc);
      n_chk++;
      if (!acc || out_ch !== CW'(seq[k]) || gr !== er)
        $display("FAIL prio_seq[%0d] got ch=%0d rdy=%b want ch=%0d rdy=%b",
                 k, out_ch, gr, seq[k], er);
      else n_pass++;
      if (acc) begin
        e = exp_q.pop_front();
        n_chk++;
        if (out_data !== e.data || out_ch !== e.ch)
          $display("FAIL prio_word[%0d] got %0d/%0d want %0d/%0d",
                   k, out_ch, out_data, e.ch, e.data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    logic [N-1:0] er, gr;
    bit acc;
    exp_t e;
    do_reset();
    set_data_mod4();
    in_data[2*DW +: DW] = 2'b11;
    out_ready = 1'b1;
    in_valid  = 8'b0000_0100;
    tick(er, gr, acc);
    n_chk++;
    if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 2'b11)
      $display("FAIL rst_pre got v=%b ch=%0d d=%0d want v=1 ch=2 d=3",
               out_valid, out_ch, out_data);
    else n_pass++;
    in_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 ||
        in_ready !== '0)
      $display("FAIL rst_async got v=%b ch=%0d d=%0d rdy=%b want 0",
               out_valid, out_ch, out_data, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mptr   = N - 1;
    mvalid = 1'b0;
    exp_q.delete();
    tick(er, gr, acc);
    n_chk++;
    if (!acc || out_ch !== 3'd0 || out_valid !== 1'b1 || gr !== 8'h01)
      $display("FAIL rst_first got ch=%0d v=%b rdy=%b want ch=0 v=1 rdy=01",
               out_ch, out_valid, gr);
    else n_pass++;
    if (acc) begin
      e = exp_q.pop_front();
      n_chk++;
      if (out_data !== e.data)
        $display("FAIL rst_data got %0d want %0d", out_data, e.data);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    mptr      = N - 1;
    mvalid    = 1'b0;
    #1;
    test_round_robin();
    test_back_pressure();
    test_sparse();
    test_drain();
    test_prio();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
